dac_offset_ctrl: RTL and testbench
==================================

Name: dac_offset_ctrl

Overview:
- Configures the four ADC-offset DACs: one serial data lane per DAC, with a shared SCLK and a shared CS_n.
- Holds a 12-bit shadow offset per lane, written by the command/config path decoded from Ethernet RX.
- Shifts all four lanes out simultaneously on request.
- Sits beside the scope datapath on sys_clk and drives the doffs/soffs_n pins in place of the fixed DAC logic.

Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles; legal range 2..255.
- CMD_BITS, 4'b0011: DAC command nibble ("write and update"), prepended to each 12-bit value.
- DEFAULT_OFFSET, 12'h800: reset value of every shadow register.
- REFRESH_PERIOD, 32'd1000000: auto-refresh interval in clk cycles; used only under the optional feature.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_cfg_wr  in  1  single-cycle write strobe for a shadow register.
- i_cfg_lane  in  2  lane index 0..3.
- i_cfg_val  in  12  offset value.
- i_update  in  1  pulse: request a transfer of all four shadows.
- o_dac_sclk  out  1  shared serial clock; idles low.
- o_dac_cs_n  out  1  shared chip select, active low.
- o_dac_data  out  4  per-lane serial data, MSB first.
- o_busy  out  1  high from the start of a transfer until the end of GAP.
- o_done  out  1  one-cycle pulse at the end of GAP.

Behaviour:
- Reset (async assert, sync release) drives these values:
  - o_dac_cs_n=1, o_dac_sclk=0, o_dac_data=0, o_busy=0, o_done=0.
  - All shadows = DEFAULT_OFFSET; state IDLE.
  - pending flag = 1, so the defaults are loaded automatically after reset.
- Shadow write: if i_cfg_wr, shadow[i_cfg_lane] <= i_cfg_val. Writes are accepted in any state.
- Frame word per lane: {CMD_BITS, shadow}, 16 bits. All four words are latched into shift registers when a transfer starts, so writes made during a transfer take effect on the next transfer only.
- If a write and a start occur in the same cycle, the start uses the new value (write-through bypass).
- pending flag:
  - Set by i_update, or by the refresh tick under the optional feature.
  - Cleared when a transfer starts.
  - i_update while busy sets pending, which causes exactly one follow-up transfer; multiple requests coalesce.
- FSM:
  - IDLE: if pending, latch words, cs_n<=0, drive bit15 on o_dac_data, busy<=1, go to LOW.
  - LOW: sclk=0 for CLK_DIV cycles, then go to HIGH.
  - HIGH: sclk=1 for CLK_DIV cycles. The DAC samples on the rising edge. On the falling-edge transition, if bits remain, shift to present the next bit and go to LOW; after bit 0, go to HOLD.
  - HOLD: sclk=0 for CLK_DIV cycles, then cs_n<=1, data<=0, go to GAP.
  - GAP: cs_n=1 for 2*CLK_DIV cycles, then o_done pulses for 1 cycle, busy<=0, go to IDLE.
- Timing:
  - cs_n stays low for exactly 33*CLK_DIV cycles (132 at default). Data is stable for the full CLK_DIV cycles before each SCLK rise.
  - A new start can occur no earlier than the cycle after o_done, so cs_n stays high for at least 2*CLK_DIV+1 cycles between frames.
- Counters:
  - Phase counter is 8-bit and counts CLK_DIV-1 down to 0.
  - Bit counter is 4-bit and counts 15 down to 0.
- Reset mid-transfer aborts immediately to the reset values, followed by the automatic defaults load. No partial frame is ever completed with cs_n held low.

Optional Feature:
- Macro DAC_OFFSET_REFRESH_EN.
- When defined: a 32-bit free-running counter raises a refresh tick every REFRESH_PERIOD cycles; the tick sets pending, so offsets are re-sent periodically (for glitch/ESD recovery). A tick that arrives while busy is coalesced.
- When undefined: the counter and tick do not exist, and transfers occur only at reset and on i_update.

Decomposition:
- Shared package dac_offset_pkg holds:
  - FSM state enum (IDLE, LOW, HIGH, HOLD, GAP).
  - Constants FRAME_BITS=16 and LANES=4.
  - Default CMD nibble.
- One natural sub-module, dac_offset_shifter: one 16-bit load/shift register per lane, instantiated 4 times, driven by common load/shift strobes from the FSM.

Test Plan:
- Reset release, no other input -> one automatic frame: cs_n low 132 cycles, each lane shifts 16'h3800, then o_done pulses once.
- Write lanes 0..3 = 12'h123, 12'h456, 12'h789, 12'hABC, then i_update -> sampled words on SCLK rising edges are 16'h3123, 16'h3456, 16'h3789, 16'h3ABC; exactly 16 SCLK rises while cs_n is low.
- i_update three times during a transfer, plus a write of lane 2 = 12'h0FF mid-frame -> current frame is unchanged, exactly one follow-up frame carries 16'h30FF on lane 2, and cs_n high gap is at least 9 cycles.
- Write lane 1 = 12'h555 in the same cycle as i_update from IDLE -> that frame carries 16'h3555 on lane 1.
- Assert rst_n low at SCLK bit 7 -> cs_n=1, sclk=0, data=0 in the same cycle; after release, a full default frame of 16'h3800 is sent.
- With DAC_OFFSET_REFRESH_EN defined and REFRESH_PERIOD=500 -> a frame starts every 500 cycles with no i_update; when undefined, no frame occurs after the reset load.

Source files
------------

// File: rtl/dac_offset_pkg.sv
// -----------------------------------------------------------------------------
// dac_offset_pkg
// Shared definitions for the ADC-offset DAC controller:
//   state_t      - transfer FSM states (IDLE, LOW, HIGH, HOLD, GAP)
//   FRAME_BITS   - bits shifted per lane per frame (4-bit command + 12-bit value)
//   LANES        - number of DACs / serial data lanes
//   DEFAULT_CMD  - "write and update" command nibble placed ahead of each value
// -----------------------------------------------------------------------------
package dac_offset_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    HOLD = 3'd3,
    GAP  = 3'd4
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int LANES      = 4;

  localparam logic [3:0] DEFAULT_CMD = 4'b0011;

endpackage

// File: rtl/dac_offset_shifter.sv
// -----------------------------------------------------------------------------
// dac_offset_shifter
// One lane's 16-bit load/shift register. The MSB is the lane's serial output.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   load        - capture word (has priority over shift)
//   shift       - move the next bit into the MSB position
//   clear       - force the register (and so the serial output) to zero
//   word        - frame word to capture on load
//   bit_out     - current serial bit (register MSB)
// -----------------------------------------------------------------------------
import dac_offset_pkg::*;

module dac_offset_shifter (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  clear,
  input  logic [FRAME_BITS-1:0] word,
  output logic                  bit_out
);

  logic [FRAME_BITS-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else if (load) begin
      sr <= word;
    end else if (shift) begin
      sr <= {sr[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign bit_out = sr[FRAME_BITS-1];

endmodule

// File: rtl/dac_offset_ctrl.sv
// -----------------------------------------------------------------------------
// dac_offset_ctrl
// Drives four ADC-offset DACs over a shared SCLK / CS_n with one serial data
// lane per DAC. Each lane has a 12-bit shadow register; a transfer sends
// {CMD_BITS, shadow} MSB first on all four lanes at once.
//
// Optional build macro DAC_OFFSET_REFRESH_EN: adds a free-running counter that
// re-requests a transfer every REFRESH_PERIOD clocks. Without the macro,
// transfers happen only after reset and on i_update.
//
// Ports:
//   clk, rst_n       - system clock, asynchronous active-low reset
//   i_cfg_wr         - one-cycle shadow write strobe
//   i_cfg_lane       - shadow index 0..3
//   i_cfg_val        - 12-bit offset value
//   i_update         - request a transfer of all four shadows
//   o_dac_sclk       - shared serial clock, idles low
//   o_dac_cs_n       - shared chip select, active low
//   o_dac_data[3:0]  - per-lane serial data
//   o_busy           - high from transfer start until the end of the gap
//   o_done           - one-cycle pulse when the gap completes
//
// Handshake: i_update is a fire-and-forget request. It sets a pending flag
// which is consumed when a transfer starts; requests arriving while a transfer
// runs collapse into a single follow-up transfer. i_cfg_wr is always accepted.
// -----------------------------------------------------------------------------
import dac_offset_pkg::*;

module dac_offset_ctrl #(
  parameter int unsigned CLK_DIV        = 4,
  parameter logic [3:0]  CMD_BITS       = DEFAULT_CMD,
  parameter logic [11:0] DEFAULT_OFFSET = 12'h800,
  parameter logic [31:0] REFRESH_PERIOD = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cfg_wr,
  input  logic [1:0]  i_cfg_lane,
  input  logic [11:0] i_cfg_val,
  input  logic        i_update,
  output logic        o_dac_sclk,
  output logic        o_dac_cs_n,
  output logic [3:0]  o_dac_data,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [7:0] PHASE_MAX = 8'(CLK_DIV - 1);

  state_t      state, state_next;
  logic [7:0]  phase, phase_next;
  logic [3:0]  bit_cnt, bit_next;
  logic        cs_n_next, sclk_next, busy_next, done_next;
  logic        load, shift, clear;
  logic        pending, start, refresh_tick;

  logic [11:0]           shadow    [LANES];
  logic [FRAME_BITS-1:0] load_word [LANES];

  // ---------------------------------------------------------------------------
  // Shadow registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) shadow[i] <= DEFAULT_OFFSET;
    end else if (i_cfg_wr) begin
      shadow[i_cfg_lane] <= i_cfg_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh tick
  // ---------------------------------------------------------------------------
`ifdef DAC_OFFSET_REFRESH_EN
  logic [31:0] refresh_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
    end else if (refresh_cnt == REFRESH_PERIOD - 32'd1) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 32'd1;
    end
  end

  assign refresh_tick = (refresh_cnt == REFRESH_PERIOD - 32'd1);
`else
  // No refresh in this build; the period only keeps the parameter list the
  // same for both builds.
  assign refresh_tick = 1'b0 && (REFRESH_PERIOD != 32'd0);
`endif

  // ---------------------------------------------------------------------------
  // Pending request. Set wins over clear so a request landing on the start
  // cycle is never lost. Reset value 1 loads the defaults after reset.
  // ---------------------------------------------------------------------------
  assign start = (state == IDLE) && pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b1;
    end else if (i_update || refresh_tick) begin
      pending <= 1'b1;
    end else if (start) begin
      pending <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Lane shifters. A write on the start cycle bypasses the shadow so the
  // frame carries the newest value.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign load_word[g] = {CMD_BITS,
                           (i_cfg_wr && (i_cfg_lane == 2'(g))) ? i_cfg_val : shadow[g]};

    dac_offset_shifter u_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .shift   (shift),
      .clear   (clear),
      .word    (load_word[g]),
      .bit_out (o_dac_data[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM: state and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= '0;
      bit_cnt    <= '0;
      o_dac_cs_n <= 1'b1;
      o_dac_sclk <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state      <= state_next;
      phase      <= phase_next;
      bit_cnt    <= bit_next;
      o_dac_cs_n <= cs_n_next;
      o_dac_sclk <= sclk_next;
      o_busy     <= busy_next;
      o_done     <= done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    phase_next = phase;
    bit_next   = bit_cnt;
    cs_n_next  = o_dac_cs_n;
    sclk_next  = o_dac_sclk;
    busy_next  = o_busy;
    done_next  = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    clear      = 1'b0;

    case (state)
      IDLE: begin
        if (pending) begin
          load       = 1'b1;
          cs_n_next  = 1'b0;
          busy_next  = 1'b1;
          phase_next = PHASE_MAX;
          bit_next   = 4'd15;
          state_next = LOW;
        end
      end

      LOW: begin
        if (phase == 8'd0) begin
          sclk_next  = 1'b1;
          phase_next = PHASE_MAX;
          state_next = HIGH;
        end else begin
          phase_next = phase - 8'd1;
        end
      end

      HIGH: begin
        if (phase == 8'd0) begin
          sclk_next  = 1'b0;
          phase_next = PHASE_MAX;
          if (bit_cnt != 4'd0) begin
            shift      = 1'b1;
            bit_next   = bit_cnt - 4'd1;
            state_next = LOW;
          end else begin
            state_next = HOLD;
          end
        end else begin
          phase_next = phase - 8'd1;
        end
      end

      HOLD: begin
        if (phase == 8'd0) begin
          cs_n_next  = 1'b1;
          clear      = 1'b1;
          phase_next = PHASE_MAX;
          // GAP is two CLK_DIV periods; the idle bit counter counts them so
          // the 8-bit phase counter never has to hold 2*CLK_DIV-1.
          bit_next   = 4'd1;
          state_next = GAP;
        end else begin
          phase_next = phase - 8'd1;
        end
      end

      GAP: begin
        if (phase == 8'd0) begin
          if (bit_cnt != 4'd0) begin
            bit_next   = bit_cnt - 4'd1;
            phase_next = PHASE_MAX;
          end else begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
          end
        end else begin
          phase_next = phase - 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dac_offset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dac_offset_ctrl
// Bench for dac_offset_ctrl. A bus monitor reassembles each CS_n-low window
// into four 16-bit words (sampled at SCLK rising edges) and compares them with
// frames predicted from a shadow-register model: frame = {CMD, shadow[lane]}.
// Build with DAC_OFFSET_REFRESH_EN to exercise the periodic refresh instead of
// the request-driven scenarios.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dac_offset_ctrl;

  localparam int          CLK_DIV   = 4;
  localparam logic [3:0]  CMD       = 4'b0011;
  localparam logic [11:0] DEF       = 12'h800;
  localparam int          FRAME_LOW = 33 * CLK_DIV;
  localparam int          MIN_GAP   = 2 * CLK_DIV + 1;
`ifdef DAC_OFFSET_REFRESH_EN
  localparam logic [31:0] REFRESH   = 32'd500;
`else
  localparam logic [31:0] REFRESH   = 32'd1000000;
`endif

  logic        clk;
  logic        rst_n;
  logic        cfg_wr;
  logic [1:0]  cfg_lane;
  logic [11:0] cfg_val;
  logic        update;
  logic        dac_sclk;
  logic        dac_cs_n;
  logic [3:0]  dac_data;
  logic        busy;
  logic        done;

  dac_offset_ctrl #(
    .CLK_DIV        (CLK_DIV),
    .CMD_BITS       (CMD),
    .DEFAULT_OFFSET (DEF),
    .REFRESH_PERIOD (REFRESH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cfg_wr   (cfg_wr),
    .i_cfg_lane (cfg_lane),
    .i_cfg_val  (cfg_val),
    .i_update   (update),
    .o_dac_sclk (dac_sclk),
    .o_dac_cs_n (dac_cs_n),
    .o_dac_data (dac_data),
    .o_busy     (busy),
    .o_done     (done)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  logic [11:0] model_shadow [4];
  logic [63:0] exp_q[$];

  function automatic logic [63:0] model_frame();
    return {CMD, model_shadow[3], CMD, model_shadow[2],
            CMD, model_shadow[1], CMD, model_shadow[0]};
  endfunction

  function automatic void model_reset();
    for (int l = 0; l < 4; l++) model_shadow[l] = DEF;
  endfunction

  // ---------------------------------------------------------------------------
  // Bus monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic [15:0] acc [4];
  int   acc_rises = 0;
  int   acc_low   = 0;
  int   gap_cnt   = 0;
  int   min_gap   = 1000000;
  int   frames    = 0;
  int   starts    = 0;
  int   done_cnt  = 0;
  int   cyc       = 0;
  int   last_start_cyc = 0;
  int   prev_start_cyc = 0;
  bit   had_frame = 1'b0;
  logic prev_sclk = 1'b0;
  logic prev_cs_n = 1'b1;

  always @(negedge clk) begin
    logic [63:0] got;
    logic [63:0] exp;
    cyc++;
    if (!rst_n) begin
      for (int l = 0; l < 4; l++) acc[l] = '0;
      acc_rises = 0;
      acc_low   = 0;
      gap_cnt   = 0;
      had_frame = 1'b0;
      prev_sclk = 1'b0;
      prev_cs_n = 1'b1;
    end else begin
      if (!dac_cs_n) begin
        if (prev_cs_n) begin
          if (had_frame && gap_cnt < min_gap) min_gap = gap_cnt;
          starts++;
          prev_start_cyc = last_start_cyc;
          last_start_cyc = cyc;
          acc_rises = 0;
          acc_low   = 0;
        end
        acc_low++;
        if (dac_sclk && !prev_sclk) begin
          for (int l = 0; l < 4; l++) acc[l] = {acc[l][14:0], dac_data[l]};
          acc_rises++;
        end
      end else if (!prev_cs_n) begin
        frames++;
        had_frame = 1'b1;
        gap_cnt   = 0;
        got = {acc[3], acc[2], acc[1], acc[0]};
        checks++;
        if (exp_q.size() == 0) begin
`ifdef DAC_OFFSET_REFRESH_EN
          if (got !== model_frame()) begin
            errors++;
            $display("FAIL refresh_frame: got %h, required %h", got, model_frame());
          end
`else
          errors++;
          $display("FAIL unexpected_frame: got %h, required no frame", got);
`endif
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL frame_words: got %h, required %h", got, exp);
          end
        end
        checks++;
        if (acc_rises != 16) begin
          errors++;
          $display("FAIL sclk_rises: got %0d, required 16", acc_rises);
        end
        checks++;
        if (acc_low != FRAME_LOW) begin
          errors++;
          $display("FAIL cs_low_len: got %0d, required %0d", acc_low, FRAME_LOW);
        end
      end
      if (dac_cs_n) gap_cnt++;
      if (done) done_cnt++;
      prev_sclk = dac_sclk;
      prev_cs_n = dac_cs_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_write(input logic [1:0] lane, input logic [11:0] val);
    @(posedge clk); #1;
    cfg_wr   = 1'b1;
    cfg_lane = lane;
    cfg_val  = val;
    model_shadow[lane] = val;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
  endtask

  task automatic pulse_update();
    @(posedge clk); #1;
    update = 1'b1;
    @(posedge clk); #1;
    update = 1'b0;
  endtask

  // Waits until every predicted frame has been seen and the DUT is idle.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < 3000);
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_timeout: frames left %0d busy %b, required 0 and 0",
               name, exp_q.size(), busy);
      exp_q.delete();
    end
    @(posedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int d0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dac_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b, required 1", dac_cs_n); end
    checks++;
    if (dac_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b, required 0", dac_sclk); end
    checks++;
    if (dac_data !== 4'h0) begin errors++; $display("FAIL reset_data: got %h, required 0", dac_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    model_reset();
    exp_q.push_back(model_frame());
    d0 = done_cnt;
    rst_n = 1'b1;
    wait_idle("reset_load");
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL reset_load_done: got %0d pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_lanes();
    int d0;
    do_write(2'd0, 12'h123);
    do_write(2'd1, 12'h456);
    do_write(2'd2, 12'h789);
    do_write(2'd3, 12'hABC);
    exp_q.push_back(model_frame());
    d0 = done_cnt;
    pulse_update();
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || dac_cs_n !== 1'b0) begin
      errors++;
      $display("FAIL lanes_active: got busy %b cs_n %b, required 1 0", busy, dac_cs_n);
    end
    wait_idle("lanes");
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL lanes_done: got %0d pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int d0, f0, n;
    min_gap = 1000000;
    exp_q.push_back(model_frame());
    d0 = done_cnt;
    f0 = frames;
    pulse_update();
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!busy) begin errors++; $display("FAIL b2b_start: got busy 0, required 1"); end
    repeat (20) @(posedge clk);
    pulse_update();
    repeat (15) @(posedge clk);
    do_write(2'd2, 12'h0FF);
    pulse_update();
    repeat (30) @(posedge clk);
    pulse_update();
    exp_q.push_back(model_frame());
    wait_idle("b2b");
    repeat (200) @(negedge clk);
    checks++;
    if (frames != f0 + 2) begin
      errors++;
      $display("FAIL b2b_frames: got %0d, required 2", frames - f0);
    end
    checks++;
    if (done_cnt != d0 + 2) begin
      errors++;
      $display("FAIL b2b_done: got %0d pulses, required 2", done_cnt - d0);
    end
    checks++;
    if (min_gap < MIN_GAP) begin
      errors++;
      $display("FAIL b2b_gap: got %0d cycles, required >= %0d", min_gap, MIN_GAP);
    end
  endtask

  task automatic test_write_with_update();
    @(posedge clk); #1;
    cfg_wr   = 1'b1;
    cfg_lane = 2'd1;
    cfg_val  = 12'h555;
    update   = 1'b1;
    model_shadow[1] = 12'h555;
    exp_q.push_back(model_frame());
    @(posedge clk); #1;
    cfg_wr = 1'b0;
    update = 1'b0;
    wait_idle("write_with_update");
  endtask

  // The write lands on the exact cycle the transfer starts.
  task automatic test_start_bypass();
    logic [11:0] v;
    v = 12'($urandom_range(0, 4095));
    @(posedge clk); #1;
    update = 1'b1;
    @(posedge clk); #1;
    update   = 1'b0;
    cfg_wr   = 1'b1;
    cfg_lane = 2'd0;
    cfg_val  = v;
    model_shadow[0] = v;
    exp_q.push_back(model_frame());
    @(posedge clk); #1;
    cfg_wr = 1'b0;
    wait_idle("start_bypass");
  endtask

  task automatic test_random();
    int d0, nw;
    for (int it = 0; it < 4; it++) begin
      nw = $urandom_range(1, 4);
      for (int k = 0; k < nw; k++) begin
        do_write(2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)));
      end
      exp_q.push_back(model_frame());
      d0 = done_cnt;
      pulse_update();
      wait_idle("random");
      checks++;
      if (done_cnt != d0 + 1) begin
        errors++;
        $display("FAIL random_done: got %0d pulses, required 1", done_cnt - d0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_write(2'd3, 12'h1E5);
    exp_q.push_back(model_frame());
    pulse_update();
    n = 0;
    while (acc_rises != 8 && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (acc_rises != 8) begin
      errors++;
      $display("FAIL reset_mid_reach: got %0d rises, required 8", acc_rises);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dac_cs_n !== 1'b1) begin errors++; $display("FAIL reset_mid_cs_n: got %b, required 1", dac_cs_n); end
    checks++;
    if (dac_sclk !== 1'b0) begin errors++; $display("FAIL reset_mid_sclk: got %b, required 0", dac_sclk); end
    checks++;
    if (dac_data !== 4'h0) begin errors++; $display("FAIL reset_mid_data: got %h, required 0", dac_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b, required 0", busy); end
    exp_q.delete();
    model_reset();
    exp_q.push_back(model_frame());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_idle("reset_mid_reload");
  endtask

`ifdef DAC_OFFSET_REFRESH_EN
  task automatic test_refresh();
    int s0, n;
    s0 = starts;
    n  = 0;
    while (starts < s0 + 2 && n < 1500) begin @(negedge clk); n++; end
    checks++;
    if (starts < s0 + 2) begin
      errors++;
      $display("FAIL refresh_starts: got %0d, required 2", starts - s0);
    end else begin
      checks++;
      if (last_start_cyc - prev_start_cyc != int'(REFRESH)) begin
        errors++;
        $display("FAIL refresh_period: got %0d, required %0d",
                 last_start_cyc - prev_start_cyc, REFRESH);
      end
    end
    wait_idle("refresh");
  endtask
`else
  task automatic test_no_refresh();
    int s0;
    s0 = starts;
    repeat (1200) @(negedge clk);
    checks++;
    if (starts != s0) begin
      errors++;
      $display("FAIL no_refresh: got %0d frames, required 0", starts - s0);
    end
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    rst_n    = 1'b0;
    cfg_wr   = 1'b0;
    cfg_lane = 2'd0;
    cfg_val  = 12'h000;
    update   = 1'b0;
    model_reset();

    test_reset();
`ifdef DAC_OFFSET_REFRESH_EN
    test_refresh();
`else
    test_lanes();
    test_back_to_back();
    test_write_with_update();
    test_start_bypass();
    test_random();
    test_reset_mid();
    test_no_refresh();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
